// File: rtl/imem_loader_pkg.sv
// Shared constants, FSM encoding and fault bit positions for the instruction memory loader.
package imem_loader_pkg;

    localparam int MEM_WIDTH_DEF  = 8;
    localparam int PC_WIDTH_DEF   = 32;
    localparam int REG_WIDTH_DEF  = 32;
    localparam int IMEM_DEPTH_DEF = 1024;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_bank.sv
// One byte-wide bank of instruction memory: synchronous write, registered read.
module imem_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/imem_loader.sv
// Banked instruction memory with a byte-stream load FSM and a 1-cycle fetch port.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(NOP_INST_DEF)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ld_start,
    input  logic [PC_WIDTH-1:0]   ld_base,
    input  logic [PC_WIDTH-1:0]   ld_len,
    input  logic                  ld_valid,
    input  logic [MEM_WIDTH-1:0]  ld_data,
    output logic                  ld_ready,
    output logic                  ld_busy,
    output logic                  ld_done,
    output logic                  ld_err,
    input  logic                  fetch_req,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    output logic                  fetch_ready,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic [1:0]            inst_fault
);

    localparam int NBANK     = INST_WIDTH / MEM_WIDTH;
    localparam int BANK_BITS = $clog2(NBANK);
    localparam int ROW_BITS  = $clog2(IMEM_DEPTH / NBANK);

    imem_state_t state, state_next;

    logic [PC_WIDTH-1:0]   ptr;
    logic [PC_WIDTH-1:0]   cnt;
    logic                  ld_fire;
    logic                  ptr_in_range;
    logic                  fetch_fire;
    logic [PC_WIDTH:0]     fetch_end;
    logic [1:0]            fault_now;
    logic [INST_WIDTH-1:0] rd_word;
    logic [INST_WIDTH-1:0] inst_hold;

    assign ld_ready     = (state == LOAD);
    assign ld_busy      = (state != IDLE);
    assign ld_done      = (state == DONE);
    assign fetch_ready  = (state == IDLE);
    assign ld_fire      = ld_ready && ld_valid;
    assign fetch_fire   = fetch_req && fetch_ready;
    assign ptr_in_range = (ptr < PC_WIDTH'(IMEM_DEPTH));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_next = (ld_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (ld_fire && cnt == PC_WIDTH'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Out-of-range bytes are still consumed so the stream length stays honest.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr    <= '0;
            cnt    <= '0;
            ld_err <= 1'b0;
        end else if (state == IDLE && ld_start) begin
            ptr    <= ld_base;
            cnt    <= ld_len;
            ld_err <= 1'b0;
        end else if (ld_fire) begin
            ptr <= ptr + PC_WIDTH'(1);
            cnt <= cnt - PC_WIDTH'(1);
            if (!ptr_in_range) begin
                ld_err <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic bank_we;
        assign bank_we = ld_fire && ptr_in_range && (ptr[BANK_BITS-1:0] == BANK_BITS'(b));

        imem_bank #(
            .DATA_WIDTH (MEM_WIDTH),
            .ADDR_WIDTH (ROW_BITS)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we),
            .waddr (ptr[BANK_BITS +: ROW_BITS]),
            .wdata (ld_data),
            .raddr (fetch_pc[BANK_BITS +: ROW_BITS]),
            .rdata (rd_word[b*MEM_WIDTH +: MEM_WIDTH])
        );
    end

    // One extra bit so a fetch near the top of the address space cannot wrap past the range check.
    assign fetch_end = {1'b0, fetch_pc} + (PC_WIDTH+1)'(NBANK);

    always_comb begin
        fault_now                 = 2'b00;
        fault_now[FAULT_MISALIGN] = (fetch_pc[BANK_BITS-1:0] != '0);
        fault_now[FAULT_RANGE]    = (fetch_end > (PC_WIDTH+1)'(IMEM_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inst_valid <= 1'b0;
            inst_fault <= 2'b00;
            inst_hold  <= '0;
        end else begin
            inst_valid <= fetch_fire;
            inst_hold  <= inst;
            if (fetch_fire) begin
                inst_fault <= fault_now;
            end
        end
    end

    // The bank read port follows fetch_pc every cycle, so idle cycles replay the last response.
    assign inst = inst_valid ? ((inst_fault != 2'b00) ? NOP_INST : rd_word) : inst_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: load, fetch, faults, range errors and reset.
module tb_imem_loader;

    localparam int DEPTH = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ld_start = 1'b0;
    logic [31:0] ld_base = '0;
    logic [31:0] ld_len = '0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_ready, ld_busy, ld_done, ld_err;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_ready, inst_valid;
    logic [31:0] inst;
    logic [1:0]  inst_fault;

    int total = 0;
    int bad = 0;

    imem_loader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ld_start    (ld_start),
        .ld_base     (ld_base),
        .ld_len      (ld_len),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_busy     (ld_busy),
        .ld_done     (ld_done),
        .ld_err      (ld_err),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_fault  (inst_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] pc, output logic [31:0] w,
                            output logic [1:0] f, output logic v);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        step();
        w = inst;
        f = inst_fault;
        v = inst_valid;
        fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        total++;
        if ({ld_busy, ld_ready, ld_done, ld_err, fetch_ready, inst_valid} !== 6'b000010) begin
            bad++;
            $display("FAIL reset_flags got %b exp 000010",
                     {ld_busy, ld_ready, ld_done, ld_err, fetch_ready, inst_valid});
        end
        total++;
        if (inst !== 32'h0 || inst_fault !== 2'b00) begin
            bad++;
            $display("FAIL reset_inst got %h/%b exp 00000000/00", inst, inst_fault);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_load_basic();
        logic [7:0]  b [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        logic [31:0] w;
        logic [1:0]  f;
        logic        v;
        int          rdy = 0;
        ld_start = 1'b1; ld_base = 32'd0; ld_len = 32'd8;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1;
            ld_data  = b[i];
            if (ld_ready === 1'b1 && ld_done === 1'b0) rdy++;
            step();
        end
        ld_valid = 1'b0;
        total++;
        if (rdy != 8) begin
            bad++;
            $display("FAIL basic_ready_cycles got %0d exp 8", rdy);
        end
        total++;
        if (ld_done !== 1'b1 || ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_done got done=%b ready=%b exp 1/0", ld_done, ld_ready);
        end
        step();
        total++;
        if (ld_done !== 1'b0 || ld_busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse got done=%b busy=%b exp 0/0", ld_done, ld_busy);
        end
        do_fetch(32'd0, w, f, v);
        total++;
        if (w !== 32'h0000_0013 || f !== 2'b00 || v !== 1'b1) begin
            bad++;
            $display("FAIL fetch0 got %h/%b/%b exp 00000013/00/1", w, f, v);
        end
        do_fetch(32'd4, w, f, v);
        total++;
        if (w !== 32'h0010_0093 || f !== 2'b00 || v !== 1'b1) begin
            bad++;
            $display("FAIL fetch4 got %h/%b/%b exp 00100093/00/1", w, f, v);
        end
        step();
        total++;
        if (inst_valid !== 1'b0 || inst !== 32'h0010_0093) begin
            bad++;
            $display("FAIL fetch_hold got %b/%h exp 0/00100093", inst_valid, inst);
        end
    endtask

    task automatic test_load_toggle();
        logic [7:0]  b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic [31:0] w;
        logic [1:0]  f;
        logic        v;
        int          done_cnt = 0;
        int          done_at = -1;
        ld_start = 1'b1; ld_base = 32'd8; ld_len = 32'd4;
        step();
        ld_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ld_valid = (k % 2 == 0);
            ld_data  = b[k/2];
            step();
            if (ld_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
        end
        ld_valid = 1'b0;
        total++;
        if (done_cnt != 1 || done_at != 6) begin
            bad++;
            $display("FAIL toggle_done got count=%0d at=%0d exp 1/6", done_cnt, done_at);
        end
        do_fetch(32'd8, w, f, v);
        total++;
        if (w !== 32'hDDCC_BBAA || f !== 2'b00 || v !== 1'b1) begin
            bad++;
            $display("FAIL toggle_fetch got %h/%b/%b exp ddccbbaa/00/1", w, f, v);
        end
    endtask

    task automatic test_fetch_faults();
        logic [31:0] pcs  [3] = '{32'd2, DEPTH, DEPTH - 2};
        logic [1:0]  exps [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] w;
        logic [1:0]  f;
        logic        v;
        for (int i = 0; i < 3; i++) begin
            do_fetch(pcs[i], w, f, v);
            total++;
            if (w !== NOP || f !== exps[i] || v !== 1'b1) begin
                bad++;
                $display("FAIL fault_pc%0d got %h/%b/%b exp %h/%b/1", pcs[i], w, f, v, NOP, exps[i]);
            end
        end
    endtask

    task automatic test_load_range();
        logic [7:0]  b [4] = '{8'h5A, 8'hA5, 8'hC3, 8'h3C};
        logic [31:0] w;
        logic [1:0]  f;
        logic        v;
        logic [3:0]  errs;
        ld_start = 1'b1; ld_base = DEPTH - 2; ld_len = 32'd4;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = b[i];
            step();
            errs[i] = ld_err;
        end
        ld_valid = 1'b0;
        total++;
        if (errs !== 4'b1100) begin
            bad++;
            $display("FAIL range_err_seq got %b exp 1100", errs);
        end
        total++;
        if (ld_done !== 1'b1) begin
            bad++;
            $display("FAIL range_done got %b exp 1", ld_done);
        end
        step();
        total++;
        if (ld_err !== 1'b1 || ld_busy !== 1'b0) begin
            bad++;
            $display("FAIL range_err_sticky got err=%b busy=%b exp 1/0", ld_err, ld_busy);
        end
        do_fetch(DEPTH - 4, w, f, v);
        total++;
        if (w[31:16] !== 16'hA55A || f !== 2'b00 || v !== 1'b1) begin
            bad++;
            $display("FAIL range_top_bytes got %h/%b/%b exp a55a/00/1", w[31:16], f, v);
        end
        ld_start = 1'b1; ld_len = 32'd0;
        step();
        ld_start = 1'b0;
        total++;
        if (ld_err !== 1'b0 || ld_done !== 1'b1) begin
            bad++;
            $display("FAIL zero_len got err=%b done=%b exp 0/1", ld_err, ld_done);
        end
        step();
        total++;
        if (ld_done !== 1'b0 || ld_busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_end got done=%b busy=%b exp 0/0", ld_done, ld_busy);
        end
    endtask

    task automatic test_reset_midload();
        logic [31:0] w;
        logic [1:0]  f;
        logic        v;
        int          done_seen = 0;
        ld_start = 1'b1; ld_base = 32'd16; ld_len = 32'd8;
        step();
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(i + 1);
            step();
        end
        ld_valid = 1'b0;
        reset_n  = 1'b0;
        step();
        reset_n = 1'b1;
        total++;
        if (ld_busy !== 1'b0 || fetch_ready !== 1'b1 || ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state got busy=%b fready=%b lready=%b exp 0/1/0",
                     ld_busy, fetch_ready, ld_ready);
        end
        for (int i = 0; i < 3; i++) begin
            if (ld_done === 1'b1) done_seen++;
            step();
        end
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("FAIL midreset_no_done got %0d exp 0", done_seen);
        end
        do_fetch(32'd16, w, f, v);
        total++;
        if (w[15:0] !== 16'h0201 || f !== 2'b00 || v !== 1'b1) begin
            bad++;
            $display("FAIL midreset_bytes got %h/%b/%b exp 0201/00/1", w[15:0], f, v);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        logic [31:0] w;
        logic [1:0]  f;
        logic        v;
        int          fr_seen = 0;
        ld_start = 1'b1; ld_base = 32'd0; ld_len = 32'd4;
        fetch_req = 1'b1; fetch_pc = 32'd0;
        step();
        ld_start = 1'b0; fetch_req = 1'b0;
        total++;
        if (inst !== 32'h0000_0013 || inst_valid !== 1'b1 || ld_busy !== 1'b1) begin
            bad++;
            $display("FAIL same_cycle got %h/%b busy=%b exp 00000013/1/1", inst, inst_valid, ld_busy);
        end
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = b[i];
            ld_start = (i == 1);
            ld_base  = 32'd100;
            ld_len   = 32'd1;
            if (fetch_ready === 1'b1) fr_seen++;
            step();
        end
        ld_valid = 1'b0; ld_start = 1'b0;
        total++;
        if (ld_done !== 1'b1 || fr_seen != 0) begin
            bad++;
            $display("FAIL b2b_done got done=%b fready_cycles=%0d exp 1/0", ld_done, fr_seen);
        end
        step();
        do_fetch(32'd0, w, f, v);
        total++;
        if (w !== 32'hDEAD_BEEF || f !== 2'b00 || v !== 1'b1) begin
            bad++;
            $display("FAIL b2b_refetch got %h/%b/%b exp deadbeef/00/1", w, f, v);
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_load_toggle();
        test_fetch_faults();
        test_load_range();
        test_reset_midload();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-addressed instruction memory split into INST_WIDTH/MEM_WIDTH byte banks, so one aligned fetch reads a whole little-endian instruction in a single access.
A load FSM replaces the raw per-word write port. It accepts a valid/ready byte stream into a base/length window, then releases the fetch port.
The fetch port has a 1-cycle registered response with alignment and range fault flags.
The block sits between the boot/debug loader and the IF stage.

Parameters:
MEM_WIDTH, 8, bits per memory location (one byte).
INST_WIDTH, 32, instruction width; must be a multiple of MEM_WIDTH; NBANK = INST_WIDTH/MEM_WIDTH.
PC_WIDTH, 32, fetch and load address width (byte address).
IMEM_DEPTH, 1024, total bytes; must be a multiple of NBANK and a power of two.
NOP_INST, 32'h0000_0013, instruction returned on a faulting fetch.

Ports:
clk  input  1  clock; all logic on rising edge.
reset_n  input  1  reset, synchronous and active-low.
ld_start  input  1  start a load; sampled only in IDLE.
ld_base  input  PC_WIDTH  first byte address of the load, latched on ld_start.
ld_len  input  PC_WIDTH  byte count of the load, latched on ld_start.
ld_valid  input  1  ld_data is valid.
ld_data  input  MEM_WIDTH  load byte.
ld_ready  output  1  block accepts a byte; equals (state==LOAD).
ld_busy  output  1  high while state!=IDLE.
ld_done  output  1  one-cycle pulse at the end of a load.
ld_err  output  1  sticky: a load byte targeted an address >= IMEM_DEPTH.
fetch_req  input  1  fetch request.
fetch_pc  input  PC_WIDTH  fetch byte address.
fetch_ready  output  1  equals (state==IDLE).
inst_valid  output  1  response valid, one cycle after an accepted fetch.
inst  output  INST_WIDTH  fetched instruction, little-endian.
inst_fault  output  2  bit0 misaligned, bit1 out of range; valid with inst_valid.

Behaviour:
- Reset (reset_n==0 at an edge): state=IDLE; ld_done=0; ld_err=0; inst_valid=0; inst=0; inst_fault=0. Memory contents are not reset.
- FSM states are IDLE, LOAD and DONE.
- IDLE:
  - ld_start with ld_len!=0: latch ptr=ld_base and cnt=ld_len, clear ld_err, go to LOAD.
  - ld_start with ld_len==0: clear ld_err, go to DONE.
- LOAD:
  - On each ld_valid && ld_ready: write ld_data to bank ptr%NBANK at row ptr/NBANK; ptr+=1; cnt-=1.
  - When cnt reaches 0 on that handshake, go to DONE.
  - Without ld_valid, state and pointers hold.
- DONE: ld_done=1 for exactly this cycle, then go to IDLE.
- ld_start outside IDLE is ignored, including mid-load.
- Out-of-range load byte (ptr>=IMEM_DEPTH, including ptr wrap past 2^PC_WIDTH-1):
  - the write is suppressed;
  - the byte is still consumed and cnt still decrements;
  - ld_err is set and stays set until the next accepted ld_start or reset.
- Fetch:
  - A fetch is accepted when fetch_req && fetch_ready.
  - On the next cycle: inst_valid=1, inst = {bank[NBANK-1]..bank[0]} at row fetch_pc/NBANK.
  - With no accepted fetch, inst_valid=0 next cycle, and inst/inst_fault hold their last values.
- Fetch faults:
  - fetch_pc%NBANK!=0 sets inst_fault[0]; fetch_pc+NBANK>IMEM_DEPTH sets inst_fault[1].
  - Both bits may be set together.
  - Any fault gives inst=NOP_INST, and the memory read result is discarded.
- Fetch and ld_start in the same IDLE cycle: both are accepted. The fetch returns pre-load contents, because the first load write occurs at the earliest one cycle later.
- Reset asserted mid-load: the FSM aborts to IDLE. Bytes already written remain; the partial load is not reported through ld_done.
- Arithmetic:
  - ptr and cnt are PC_WIDTH bits.
  - The row index is the upper address bits above log2(NBANK), truncated to log2(IMEM_DEPTH/NBANK) after the range check.

Decomposition:
- Shared define header (risc_v_defines.vh): MEM_WIDTH, PC_WIDTH, REG_WIDTH defaults, NOP_INST constant, IMEM_DEPTH default, IMEM FSM state encodings (IDLE=2'd0, LOAD=2'd1, DONE=2'd2), fault bit indices.
- One sub-module, imem_bank: single-byte-wide synchronous RAM with one write port (we, waddr, wdata) and one registered read port (raddr, rdata). Instantiate it NBANK times with a generate loop. Fault muxing and inst_valid live in the top level.

Test Plan:
- Load ld_base=0, ld_len=8, bytes 13 00 00 00 93 00 10 00 (ld_valid always 1) -> ld_ready for 8 cycles, ld_done pulse 1 cycle after the 8th byte. Then fetch_pc=0 gives inst=32'h00000013 and fetch_pc=4 gives 32'h00100093, each with inst_valid 1 cycle after req and inst_fault=0.
- Load of 4 bytes with ld_valid toggling 1,0,1,0,... -> exactly 4 writes, ld_done only after the 4th handshake, contents correct on a fetch.
- Fetch fetch_pc=2 -> inst=NOP_INST, inst_fault=2'b01. Fetch fetch_pc=IMEM_DEPTH -> inst=NOP_INST, inst_fault=2'b10. Fetch fetch_pc=IMEM_DEPTH-2 -> inst_fault=2'b11.
- Load ld_base=IMEM_DEPTH-2, ld_len=4 -> 2 in-range writes, ld_err=1 from the 3rd byte, ld_done pulses, and IMEM_DEPTH-1 holds byte 2. A subsequent ld_start with ld_len=0 clears ld_err and pulses ld_done on the next cycle.
- Assert reset_n=0 for one cycle after 2 of 8 load bytes -> IDLE, ld_busy=0, no ld_done, fetch_ready=1, first 2 bytes readable.
- Fetch and ld_start in the same cycle to the same word -> old instruction returned; after ld_done, a re-fetch returns the new word; ld_start during LOAD has no effect.
